// File: rtl/resource_pool_lock_mc_if.sv
// Request/grant bundle between issue ports (master) and the multi-class resource pool lock (slave).
interface resource_pool_lock_mc_if #(
  parameter int NUM_RESOURCES = 4,
  parameter int NUM_PORTS     = 4,
  parameter int ID_WIDTH      = 6,
  parameter int NUM_CLASSES   = 2
);
  localparam int RES_W = (NUM_RESOURCES > 1) ? $clog2(NUM_RESOURCES) : 1;
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CNT_W = $clog2(NUM_RESOURCES + 1);

  logic [NUM_PORTS-1:0]               req;
  logic [NUM_PORTS-1:0][CLS_W-1:0]    req_class;
  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_issue_id;
  logic [NUM_PORTS-1:0]               release_lock;
  logic                               flush;
  logic [ID_WIDTH-1:0]                flush_id;
  logic [NUM_PORTS-1:0]               grant;
  logic [NUM_PORTS-1:0][RES_W-1:0]    alloc_id;
  logic [NUM_PORTS-1:0]               revoked;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]  free_count;
  logic [NUM_CLASSES-1:0]             pool_busy;

  modport master (
    output req, req_class, req_issue_id, release_lock, flush, flush_id,
    input  grant, alloc_id, revoked, free_count, pool_busy
  );

  modport slave (
    input  req, req_class, req_issue_id, release_lock, flush, flush_id,
    output grant, alloc_id, revoked, free_count, pool_busy
  );
endinterface

// File: rtl/resource_pool_lock_mc.sv
// Multi-class, age-ordered resource pool lock with lease watchdog and flush squash.
// Resource r belongs to class r % NUM_CLASSES; the oldest requester (wrap-around issue ID) wins.
module resource_pool_lock_mc #(
  parameter int NUM_RESOURCES = 4,
  parameter int NUM_PORTS     = 4,
  parameter int ID_WIDTH      = 6,
  parameter int NUM_CLASSES   = 2,
  parameter int LEASE_MAX     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  resource_pool_lock_mc_if.slave bus
);
  localparam int RES_W   = (NUM_RESOURCES > 1) ? $clog2(NUM_RESOURCES) : 1;
  localparam int PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W   = $clog2(NUM_RESOURCES + 1);
  localparam int LEASE_W = (LEASE_MAX > 0) ? $clog2(LEASE_MAX + 1) : 1;
  localparam bit LEASE_ON = (LEASE_MAX > 0);
  localparam logic [LEASE_W:0] LEASE_LIM = (LEASE_W + 1)'(LEASE_MAX);
  localparam logic [LEASE_W:0] LEASE_ONE = (LEASE_W + 1)'(1'b1);

  // a is older than b when the wrapped difference has its top bit set.
  function automatic logic is_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
    logic [ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[ID_WIDTH-1];
  endfunction

  logic [NUM_RESOURCES-1:0]               valid_r;
  logic [NUM_RESOURCES-1:0][PORT_W-1:0]   port_r;
  logic [NUM_RESOURCES-1:0][ID_WIDTH-1:0] id_r;
  logic [NUM_RESOURCES-1:0][LEASE_W-1:0]  lease_r;
  logic [NUM_PORTS-1:0]                   revoked_r;

  logic [NUM_RESOURCES-1:0]               keep_s;
  logic [NUM_PORTS-1:0]                   held_grant_s;
  logic [NUM_PORTS-1:0][RES_W-1:0]        held_alloc_s;
  logic [NUM_PORTS-1:0]                   cand_left_s;
  logic                                   take_s;
  logic                                   found_s;
  logic [PORT_W-1:0]                      best_s;
  logic [NUM_RESOURCES-1:0]               new_valid_s;
  logic [NUM_RESOURCES-1:0][PORT_W-1:0]   new_port_s;
  logic [NUM_PORTS-1:0]                   new_grant_s;
  logic [NUM_PORTS-1:0][RES_W-1:0]        new_alloc_s;
  logic [NUM_PORTS-1:0]                   grant_s;
  logic [NUM_PORTS-1:0][RES_W-1:0]        alloc_s;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]      free_cnt_s;
  logic [NUM_CLASSES-1:0]                 busy_s;
  logic [LEASE_W:0]                       lease_sum_s;
  logic [NUM_RESOURCES-1:0]               valid_nxt_s;
  logic [NUM_RESOURCES-1:0][PORT_W-1:0]   port_nxt_s;
  logic [NUM_RESOURCES-1:0][ID_WIDTH-1:0] id_nxt_s;
  logic [NUM_RESOURCES-1:0][LEASE_W-1:0]  lease_nxt_s;
  logic [NUM_PORTS-1:0]                   revoke_nxt_s;

  // Held entries survive unless their owner releases or they are squashed by flush.
  always_comb begin
    keep_s       = '0;
    held_grant_s = '0;
    held_alloc_s = '0;
    for (int r = 0; r < NUM_RESOURCES; r++) begin
      if (valid_r[r] && !bus.release_lock[port_r[r]] &&
          !(bus.flush && is_older(bus.flush_id, id_r[r]))) begin
        keep_s[r]                 = 1'b1;
        held_grant_s[port_r[r]]   = 1'b1;
        held_alloc_s[port_r[r]]   = RES_W'(r);
      end else begin
        keep_s[r] = 1'b0;
      end
    end
  end

  // Each free resource, in ascending index order, takes the oldest remaining candidate of its class.
  always_comb begin
    cand_left_s = '0;
    new_valid_s = '0;
    new_port_s  = '0;
    new_grant_s = '0;
    new_alloc_s = '0;
    take_s      = 1'b0;
    found_s     = 1'b0;
    best_s      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cand_left_s[p] = bus.req[p] && !held_grant_s[p] &&
                       !(bus.flush && is_older(bus.flush_id, bus.req_issue_id[p]));
    end
    for (int r = 0; r < NUM_RESOURCES; r++) begin
      found_s = 1'b0;
      best_s  = '0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        // Strictly-older replaces, so equal IDs leave the lower port in place.
        take_s  = !keep_s[r] && cand_left_s[q] &&
                  (int'(bus.req_class[q]) == (r % NUM_CLASSES)) &&
                  (!found_s || is_older(bus.req_issue_id[q], bus.req_issue_id[best_s]));
        best_s  = take_s ? PORT_W'(q) : best_s;
        found_s = found_s || take_s;
      end
      if (found_s) begin
        new_valid_s[r]      = 1'b1;
        new_port_s[r]       = best_s;
        cand_left_s[best_s] = 1'b0;
        new_grant_s[best_s] = 1'b1;
        new_alloc_s[best_s] = RES_W'(r);
      end else begin
        new_valid_s[r] = 1'b0;
      end
    end
  end

  // Table contents and revoke pulses for the next edge, including lease expiry.
  always_comb begin
    valid_nxt_s  = '0;
    port_nxt_s   = '0;
    id_nxt_s     = '0;
    lease_nxt_s  = '0;
    revoke_nxt_s = '0;
    lease_sum_s  = '0;
    for (int r = 0; r < NUM_RESOURCES; r++) begin
      if (keep_s[r]) begin
        lease_sum_s = {1'b0, lease_r[r]} + LEASE_ONE;
        if (LEASE_ON && (lease_sum_s == LEASE_LIM)) begin
          revoke_nxt_s[port_r[r]] = 1'b1;
        end else begin
          valid_nxt_s[r] = 1'b1;
          port_nxt_s[r]  = port_r[r];
          id_nxt_s[r]    = id_r[r];
          lease_nxt_s[r] = lease_sum_s[LEASE_W-1:0];
        end
      end else if (new_valid_s[r] && !bus.release_lock[new_port_s[r]]) begin
        if (LEASE_ON && (LEASE_ONE == LEASE_LIM)) begin
          revoke_nxt_s[new_port_s[r]] = 1'b1;
        end else begin
          valid_nxt_s[r] = 1'b1;
          port_nxt_s[r]  = new_port_s[r];
          id_nxt_s[r]    = bus.req_issue_id[new_port_s[r]];
          lease_nxt_s[r] = LEASE_ONE[LEASE_W-1:0];
        end
      end else begin
        valid_nxt_s[r] = 1'b0;
      end
    end
  end

  // Owner table and revoke flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= '0;
      port_r    <= '0;
      id_r      <= '0;
      lease_r   <= '0;
      revoked_r <= '0;
    end else begin
      valid_r   <= valid_nxt_s;
      port_r    <= port_nxt_s;
      id_r      <= id_nxt_s;
      lease_r   <= lease_nxt_s;
      revoked_r <= revoke_nxt_s;
    end
  end

  // Combinational grant view and per-class free accounting; reset shows an empty pool.
  always_comb begin
    grant_s    = '0;
    alloc_s    = '0;
    free_cnt_s = '0;
    busy_s     = '0;
    if (rst) begin
      for (int r = 0; r < NUM_RESOURCES; r++) begin
        free_cnt_s[r % NUM_CLASSES] = free_cnt_s[r % NUM_CLASSES] + CNT_W'(1'b1);
      end
    end else begin
      grant_s = held_grant_s | new_grant_s;
      for (int p = 0; p < NUM_PORTS; p++) begin
        alloc_s[p] = held_grant_s[p] ? held_alloc_s[p] : new_alloc_s[p];
      end
      for (int r = 0; r < NUM_RESOURCES; r++) begin
        free_cnt_s[r % NUM_CLASSES] = free_cnt_s[r % NUM_CLASSES] +
                                      ((keep_s[r] || new_valid_s[r]) ? CNT_W'(1'b0) : CNT_W'(1'b1));
      end
    end
    for (int c = 0; c < NUM_CLASSES; c++) begin
      busy_s[c] = (free_cnt_s[c] == CNT_W'(1'b0));
    end
  end

  assign bus.grant      = grant_s;
  assign bus.alloc_id   = alloc_s;
  assign bus.revoked    = revoked_r;
  assign bus.free_count = free_cnt_s;
  assign bus.pool_busy  = busy_s;
endmodule

// File: tb/tb_resource_pool_lock_mc.sv
// Randomized and directed checks of resource_pool_lock_mc against a queue-based reference model.
module tb_resource_pool_lock_mc;
  localparam int NR = 4;
  localparam int NP = 4;
  localparam int IDW = 4;
  localparam int NC = 2;
  localparam int LM = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resource_pool_lock_mc_if #(.NUM_RESOURCES(NR), .NUM_PORTS(NP), .ID_WIDTH(IDW), .NUM_CLASSES(NC)) bus ();

  resource_pool_lock_mc #(
    .NUM_RESOURCES(NR), .NUM_PORTS(NP), .ID_WIDTH(IDW), .NUM_CLASSES(NC), .LEASE_MAX(LM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: who owns which resource, for how many grant cycles so far.
  bit m_valid[NR];
  int m_port[NR];
  int m_id[NR];
  int m_lease[NR];
  bit m_revoked[NP];
  bit n_valid[NR];
  int n_port[NR];
  int n_id[NR];
  int n_lease[NR];
  bit n_revoked[NP];
  bit e_grant[NP];
  int e_alloc[NP];
  int e_free[NC];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit older(input int a, input int b);
    return ((a - b + 16) % 16) >= 8;
  endfunction

  task automatic model_eval();
    bit taken[NR];
    int cq[$];
    int fq[$];
    int p;
    int r;
    int pos;
    for (int i = 0; i < NP; i++) begin
      e_grant[i] = 1'b0; e_alloc[i] = 0; n_revoked[i] = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      n_valid[i] = 1'b0; n_port[i] = 0; n_id[i] = 0; n_lease[i] = 0; taken[i] = 1'b0;
    end
    for (int c = 0; c < NC; c++) begin
      e_free[c] = 0;
      for (int i = 0; i < NR; i++) if (i % NC == c) e_free[c]++;
    end
    if (rst) return;
    for (int i = 0; i < NR; i++) begin
      if (m_valid[i]) begin
        p = m_port[i];
        if (!bus.release_lock[p] && !(bus.flush && older(int'(bus.flush_id), m_id[i]))) begin
          e_grant[p] = 1'b1; e_alloc[p] = i; taken[i] = 1'b1;
          if (m_lease[i] + 1 == LM) n_revoked[p] = 1'b1;
          else begin
            n_valid[i] = 1'b1; n_port[i] = p; n_id[i] = m_id[i]; n_lease[i] = m_lease[i] + 1;
          end
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      cq.delete();
      fq.delete();
      for (int q = 0; q < NP; q++) begin
        if (bus.req[q] && !e_grant[q] && int'(bus.req_class[q]) == c &&
            !(bus.flush && older(int'(bus.flush_id), int'(bus.req_issue_id[q])))) begin
          pos = cq.size();
          for (int j = cq.size() - 1; j >= 0; j--) begin
            if (older(int'(bus.req_issue_id[q]), int'(bus.req_issue_id[cq[j]]))) pos = j;
          end
          cq.insert(pos, q);
        end
      end
      for (int i = 0; i < NR; i++) if (i % NC == c && !taken[i]) fq.push_back(i);
      for (int k = 0; k < cq.size() && k < fq.size(); k++) begin
        p = cq[k]; r = fq[k];
        e_grant[p] = 1'b1; e_alloc[p] = r; taken[r] = 1'b1;
        if (!bus.release_lock[p]) begin
          n_valid[r] = 1'b1; n_port[r] = p; n_id[r] = int'(bus.req_issue_id[p]); n_lease[r] = 1;
        end
      end
      e_free[c] = 0;
      for (int i = 0; i < NR; i++) if (i % NC == c && !taken[i]) e_free[c]++;
    end
  endtask

  task automatic drive_idle();
    bus.req = '0; bus.req_class = '0; bus.req_issue_id = '0;
    bus.release_lock = '0; bus.flush = 1'b0; bus.flush_id = '0;
  endtask

  task automatic set_req(input int p, input int cls, input int id);
    bus.req[p] = 1'b1;
    bus.req_class[p] = 1'(cls);
    bus.req_issue_id[p] = 4'(id);
  endtask

  task automatic check_cycle();
    #1;
    model_eval();
    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("grant[%0d]", p), int'(bus.grant[p]), int'(e_grant[p]));
      check_eq($sformatf("alloc_id[%0d]", p), int'(bus.alloc_id[p]), e_alloc[p]);
      check_eq($sformatf("revoked[%0d]", p), int'(bus.revoked[p]), int'(m_revoked[p]));
    end
    for (int c = 0; c < NC; c++) begin
      check_eq($sformatf("free_count[%0d]", c), int'(bus.free_count[c]), e_free[c]);
      check_eq($sformatf("pool_busy[%0d]", c), int'(bus.pool_busy[c]), int'(e_free[c] == 0));
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    m_valid = n_valid; m_port = n_port; m_id = n_id; m_lease = n_lease; m_revoked = n_revoked;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive_idle();
    check_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    check_cycle();
    check_eq("rst_free0", int'(bus.free_count[0]), 2);
    check_eq("rst_busy0", int'(bus.pool_busy[0]), 0);
    next_cycle();
    rst = 1'b0;

    // Wrap-around age: 14 and 15 are older than 1.
    set_req(0, 0, 14); set_req(1, 0, 1); set_req(2, 0, 15);
    check_cycle();
    check_eq("age_g0", int'(bus.grant[0]), 1);
    check_eq("age_a0", int'(bus.alloc_id[0]), 0);
    check_eq("age_g2", int'(bus.grant[2]), 1);
    check_eq("age_a2", int'(bus.alloc_id[2]), 2);
    check_eq("age_g1", int'(bus.grant[1]), 0);
    check_eq("age_free0", int'(bus.free_count[0]), 0);
    check_eq("age_busy0", int'(bus.pool_busy[0]), 1);
    check_eq("age_free1", int'(bus.free_count[1]), 2);
    next_cycle();

    // Release reuse in the same cycle.
    bus.release_lock[0] = 1'b1; set_req(1, 0, 3);
    check_cycle();
    check_eq("rel_g0", int'(bus.grant[0]), 0);
    check_eq("rel_g1", int'(bus.grant[1]), 1);
    check_eq("rel_a1", int'(bus.alloc_id[1]), 0);
    next_cycle();
    check_cycle();
    check_eq("rel_hold_g1", int'(bus.grant[1]), 1);
    check_eq("rel_hold_a1", int'(bus.alloc_id[1]), 0);
    next_cycle();
    apply_reset();

    // Lease expiry after LM grant cycles.
    set_req(3, 1, 0);
    check_cycle();
    check_eq("lease_T_g3", int'(bus.grant[3]), 1);
    check_eq("lease_T_a3", int'(bus.alloc_id[3]), 1);
    next_cycle();
    check_cycle();
    check_eq("lease_T1_g3", int'(bus.grant[3]), 1);
    next_cycle();
    check_cycle();
    check_eq("lease_T2_g3", int'(bus.grant[3]), 1);
    next_cycle();
    set_req(0, 1, 2);
    check_cycle();
    check_eq("lease_T3_g3", int'(bus.grant[3]), 0);
    check_eq("lease_T3_rev3", int'(bus.revoked[3]), 1);
    check_eq("lease_T3_g0", int'(bus.grant[0]), 1);
    check_eq("lease_T3_a0", int'(bus.alloc_id[0]), 1);
    next_cycle();
    check_cycle();
    check_eq("lease_T4_rev3", int'(bus.revoked[3]), 0);
    next_cycle();
    apply_reset();

    // Flush squashes IDs strictly younger than flush_id.
    set_req(0, 0, 5); set_req(1, 0, 9);
    check_cycle();
    next_cycle();
    bus.flush = 1'b1; bus.flush_id = 4'd7; set_req(2, 0, 8); set_req(3, 0, 6);
    check_cycle();
    check_eq("flush_g0", int'(bus.grant[0]), 1);
    check_eq("flush_g1", int'(bus.grant[1]), 0);
    check_eq("flush_g2", int'(bus.grant[2]), 0);
    check_eq("flush_g3", int'(bus.grant[3]), 1);
    check_eq("flush_a3", int'(bus.alloc_id[3]), 2);
    next_cycle();
    apply_reset();

    // Class isolation: class 0 full, class 1 still allocates.
    set_req(0, 0, 1); set_req(1, 0, 3);
    check_cycle();
    next_cycle();
    set_req(2, 1, 2); set_req(3, 1, 4);
    check_cycle();
    check_eq("iso_a2", int'(bus.alloc_id[2]), 1);
    check_eq("iso_a3", int'(bus.alloc_id[3]), 3);
    check_eq("iso_busy0", int'(bus.pool_busy[0]), 1);
    check_eq("iso_busy1", int'(bus.pool_busy[1]), 1);
    next_cycle();
    bus.release_lock[3] = 1'b1; set_req(3, 0, 5);
    check_cycle();
    check_eq("iso_deny_g3", int'(bus.grant[3]), 0);
    check_eq("iso_g2", int'(bus.grant[2]), 1);
    next_cycle();
    apply_reset();

    // Reset mid-operation with an expiry pending.
    set_req(0, 0, 1); set_req(1, 1, 2); set_req(2, 0, 3);
    check_cycle();
    next_cycle();
    check_cycle();
    next_cycle();
    rst = 1'b1;
    check_cycle();
    for (int p = 0; p < NP; p++) check_eq($sformatf("mrst_g%0d", p), int'(bus.grant[p]), 0);
    check_eq("mrst_free0", int'(bus.free_count[0]), 2);
    check_eq("mrst_free1", int'(bus.free_count[1]), 2);
    next_cycle();
    rst = 1'b0;
    set_req(3, 0, 4);
    check_cycle();
    for (int p = 0; p < NP; p++) check_eq($sformatf("post_rev%0d", p), int'(bus.revoked[p]), 0);
    check_eq("post_a3", int'(bus.alloc_id[3]), 0);
    check_eq("post_free1", int'(bus.free_count[1]), 2);
    next_cycle();

    // Random traffic; IDs per cycle stay within half the ID space so age order is total.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 99) < 3);
      base = $urandom_range(0, 15);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 99) < 60) set_req(p, $urandom_range(0, 1), (base + $urandom_range(0, 7)) % 16);
        bus.release_lock[p] = ($urandom_range(0, 99) < 20);
      end
      bus.flush = ($urandom_range(0, 99) < 15);
      bus.flush_id = 4'($urandom_range(0, 15));
      check_cycle();
      next_cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
